uart_rx_oversample: RTL and testbench



---
 rtl/uart_rx_oversample.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver: 2-flop synchronizer, 7/8/9 majority vote, false-start
// rejection and stop-bit check. Define UART_RX_PARITY_EN for 8E1 frames with parity_err.
module uart_rx_oversample #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_t;
  localparam state_t AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
  } state_t;
  localparam state_t AFTER_DATA = S_STOP;
`endif

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       smp_q, smp_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             rx_busy_q, rx_busy_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic rxs_s, tick_s, mid_s, end_s, vote_s, start_det_s, done_s;

  assign rxs_s       = sync_q[1];
  assign tick_s      = (div_q == DIV_LAST);
  assign mid_s       = tick_s && (idx_q == 4'd9);
  assign end_s       = tick_s && (idx_q == 4'd15);
  assign vote_s      = maj3(smp_q[0], smp_q[1], rxs_s);
  assign start_det_s = (state_q == S_IDLE) && armed_q && !rxs_s;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_det_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (mid_s && vote_s) begin
          state_d = S_IDLE;
        end else if (end_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (mid_s) begin
          shift_d = {vote_s, shift_q[7:1]};
        end else begin
          shift_d = shift_q;
        end
        if (end_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_s) begin
          par_d = vote_s;
        end else begin
          par_d = par_q;
        end
        if (end_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      // Leaving at the stop-bit midpoint lets a back-to-back start edge be caught.
      S_STOP: begin
        if (mid_s) begin
          state_d = S_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_data_d   = done_s ? shift_q : rx_data_q;
    rx_valid_d  = done_s & vote_s;
    frame_err_d = done_s & ~vote_s;
`ifdef UART_RX_PARITY_EN
    parity_err_d = done_s & ((^shift_q) ^ par_q);
`else
    parity_err_d = 1'b0;
`endif
    rx_busy_d = (state_d != S_IDLE);
    // Arming needs rxs seen high in IDLE, so a held-low break never retriggers.
    armed_d   = (state_d == S_IDLE) ? (armed_q | rxs_s) : 1'b0;
    div_d     = (state_d == S_IDLE) ? '0 : (tick_s ? '0 : div_q + CNT_W'(1));
    idx_d     = (state_d == S_IDLE) ? 4'd0 : (tick_s ? idx_q + 4'd1 : idx_q);
    smp_d     = smp_q;
    if (tick_s && (idx_q == 4'd7)) begin
      smp_d[0] = rxs_s;
    end else if (tick_s && (idx_q == 4'd8)) begin
      smp_d[1] = rxs_s;
    end else begin
      smp_d = smp_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      armed_q      <= 1'b0;
      div_q        <= '0;
      idx_q        <= 4'd0;
      smp_q        <= 2'b11;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], rx_in};
      armed_q      <= armed_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      smp_q        <= smp_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      rx_busy_q    <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample (16 clk per bit): directed table, corner
// sequences and randomized frames scored against a frame-level reference model.
module tb_uart_rx_oversample;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int BIT_CLK = 16;
  localparam int LAT_NOM = PAR_EN ? 170 : 154;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, rx_busy;

  uart_rx_oversample #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         flip;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  orphan_perr = 0;
  int  both_cnt = 0;

  // Capture every completion pulse together with the byte presented alongside it.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid || frame_err) begin
        got_q.push_back({rx_data, rx_valid, frame_err, parity_err});
      end else if (parity_err) begin
        orphan_perr++;
      end
      if (rx_valid && frame_err) both_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int flip_off);
    for (int k = 0; k < BIT_CLK; k++) begin
      rx_in = (k == flip_off) ? ~v : v;
      wait_cyc(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                            input int flip_off, input int gap_clk);
    drive_bit(1'b0, -1);
    for (int b = 0; b < 8; b++) drive_bit(d[b], flip_off);
    if (PAR_EN) drive_bit(pbit, -1);
    drive_bit(stop, -1);
    if (gap_clk > 0) begin
      rx_in = 1'b1;
      wait_cyc(gap_clk);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Frame-level model: one completion per frame, the stop bit selects valid vs framing error.
  function automatic ev_t model(input logic [7:0] d, input logic stop, input logic pbit);
    ev_t e;
    e.data  = d;
    e.valid = stop;
    e.ferr  = ~stop;
    e.perr  = PAR_EN ? (even_par(d) ^ pbit) : 1'b0;
    return e;
  endfunction

  task automatic drain(input string name);
    ev_t e, g;
    wait_cyc(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s actual=no_event required=data 0x%0h", name, e.data);
      end else begin
        g = got_q.pop_front();
        check({name, ".data"}, g.data, e.data);
        check({name, ".v_f_p"}, {g.valid, g.ferr, g.perr}, {e.valid, e.ferr, e.perr});
      end
    end
    check({name, ".extra_events"}, got_q.size(), 0);
    got_q.delete();
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] d;
    logic       stop, pbit;
    int         flip, gap, lat, busy_hi;
    bit         seen, busy_seen;
    ev_t        e;

    vecs[0] = '{8'h00, 1'b1, -1, 0,  8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, -1, 0,  8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, -1, 32, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'h96, 1'b1, 8,  32, 8'h96, 1'b1, 1'b0};
    vecs[4] = '{8'h69, 1'b1, 7,  16, 8'h69, 1'b1, 1'b0};
    vecs[5] = '{8'hE1, 1'b0, -1, 32, 8'hE1, 1'b0, 1'b1};
    vecs[6] = '{8'h4B, 1'b1, 9,  16, 8'h4B, 1'b1, 1'b0};

    // Reset state
    wait_cyc(3);
    check("rst.rx_data", rx_data, 8'h00);
    check("rst.rx_valid", rx_valid, 1'b0);
    check("rst.frame_err", frame_err, 1'b0);
    check("rst.parity_err", parity_err, 1'b0);
    check("rst.rx_busy", rx_busy, 1'b0);
    rst = 1'b1;
    wait_cyc(8);

    // 0xA5 with latency measured from the first clock edge that sees the start bit
    lat = 0;
    seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, even_par(8'hA5), -1, 32);
      begin
        for (int c = 0; c < 400 && !seen; c++) begin
          @(posedge clk);
          #1;
          if (rx_valid) begin
            seen = 1'b1;
            lat = c;
          end
        end
      end
    join
    total++;
    if (!seen || lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
      bad++;
      $display("FAIL latency actual=%0d required=%0d+-1", lat, LAT_NOM);
    end
    exp_q.push_back(model(8'hA5, 1'b1, even_par(8'hA5)));
    drain("a5");

    // Directed table: back-to-back frames, sample flips, framing error
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, even_par(vecs[i].data), vecs[i].flip, vecs[i].gap);
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_ferr, 1'b0});
    end
    drain("vec");

    // Stop bit low then a 40-bit break: one framing error, no retrigger while low
    send_frame(8'h55, 1'b0, even_par(8'h55), -1, 0);
    exp_q.push_back(model(8'h55, 1'b0, even_par(8'h55)));
    rx_in = 1'b0;
    busy_hi = 0;
    for (int c = 0; c < 40 * BIT_CLK; c++) begin
      wait_cyc(1);
      if (rx_busy) busy_hi++;
    end
    check("break.busy_cycles", busy_hi, 0);
    drain("break");
    rx_in = 1'b1;
    wait_cyc(32);
    send_frame(8'h12, 1'b1, even_par(8'h12), -1, 32);
    exp_q.push_back(model(8'h12, 1'b1, even_par(8'h12)));
    drain("after_break");

    // 5-clk low glitch on an idle line
    busy_seen = 1'b0;
    rx_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      wait_cyc(1);
      if (rx_busy) busy_seen = 1'b1;
    end
    rx_in = 1'b1;
    check("glitch.busy_rose", busy_seen, 1'b1);
    wait_cyc(10);
    check("glitch.busy_dropped", rx_busy, 1'b0);
    wait_cyc(40);
    drain("glitch");

    // Reset in the middle of data bit 4
    d = 8'h5A;
    drive_bit(1'b0, -1);
    for (int b = 0; b < 4; b++) drive_bit(d[b], -1);
    rx_in = d[4];
    wait_cyc(8);
    check("midrst.busy_before", rx_busy, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst.rx_data", rx_data, 8'h00);
    check("midrst.rx_busy", rx_busy, 1'b0);
    check("midrst.pulses", {rx_valid, frame_err, parity_err}, 3'b000);
    rx_in = 1'b1;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(20);
    send_frame(8'hC3, 1'b1, even_par(8'hC3), -1, 32);
    exp_q.push_back(model(8'hC3, 1'b1, even_par(8'hC3)));
    drain("after_rst");

    // Randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) flip = int'($urandom_range(7, 9));
      else flip = -1;
      pbit = even_par(d) ^ ($urandom_range(0, 3) == 0);
      if (stop) gap = 8 * int'($urandom_range(0, 2));
      else gap = 16 + int'($urandom_range(0, 16));
      send_frame(d, stop, pbit, flip, gap);
      exp_q.push_back(model(d, stop, pbit));
    end
    rx_in = 1'b1;
    wait_cyc(20);
    drain("rand");

`ifdef UART_RX_PARITY_EN
    // Wrong parity: 0x07 has odd weight, so a parity bit of 0 must be flagged
    send_frame(8'h07, 1'b1, 1'b0, -1, 32);
    e = '{data: 8'h07, valid: 1'b1, ferr: 1'b0, perr: 1'b1};
    exp_q.push_back(e);
    drain("parity");
`endif

    check("orphan_parity_err", orphan_perr, 0);
    check("valid_with_ferr", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
